// File: rtl/bus_pkg.sv
// Shared address map, timing defaults, FSM encoding and decode helper
// for the CPU bus decoder.
package bus_pkg;

  localparam int unsigned ADDR_W = 24;

  localparam logic [ADDR_W-1:0] DRAM_BASE  = 24'h000000;
  localparam logic [ADDR_W-1:0] DRAM_LIMIT = 24'h3FFFFF;
  localparam logic [ADDR_W-1:0] IO_BASE    = 24'hE00000;
  localparam logic [ADDR_W-1:0] IO_LIMIT   = 24'hEFFFFF;
  localparam logic [ADDR_W-1:0] ROM_BASE   = 24'hF00000;
  localparam logic [ADDR_W-1:0] ROM_LIMIT  = 24'hFFFFFF;

  localparam int unsigned ROM_WAIT_DEF     = 2;
  localparam int unsigned IO_WAIT_DEF      = 4;
  localparam int unsigned BERR_TIMEOUT_DEF = 64;
  localparam int unsigned BOOT_CYCLES_DEF  = 4;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_ACTIVE = 2'd1;
  localparam logic [ST_W-1:0] ST_TERM   = 2'd2;

  typedef enum logic [1:0] {
    REGION_NONE,
    REGION_DRAM,
    REGION_ROM,
    REGION_IO
  } region_e;

  // Windows are naturally aligned power-of-two blocks, so a mask test suffices
  function automatic logic in_window(logic [ADDR_W-1:0] a,
                                     logic [ADDR_W-1:0] base,
                                     logic [ADDR_W-1:0] limit);
    return (a & ~(base ^ limit)) == base;
  endfunction

  function automatic region_e decode(logic [ADDR_W-1:1] addr, logic overlay);
    logic [ADDR_W-1:0] a;
    a = {addr, 1'b0};
    if (in_window(a, DRAM_BASE, DRAM_LIMIT)) return overlay ? REGION_ROM : REGION_DRAM;
    if (in_window(a, IO_BASE, IO_LIMIT))     return REGION_IO;
    if (in_window(a, ROM_BASE, ROM_LIMIT))   return REGION_ROM;
    return REGION_NONE;
  endfunction

endpackage

// File: rtl/bus_decoder_if.sv
// CPU-side bus signals seen by the decoder; all strobes and selects active-low.
interface bus_decoder_if;
  import bus_pkg::*;

  logic              AS;
  logic              UDS;
  logic              LDS;
  logic              RW;
  logic [ADDR_W-1:1] ADDR_IN;
  logic              DTACK_DRAM;
  logic              CS_DRAM;
  logic              CS_ROM;
  logic              CS_IO;
  logic              DTACK;
  logic              BERR;

  modport master (
    output AS, UDS, LDS, RW, ADDR_IN, DTACK_DRAM,
    input  CS_DRAM, CS_ROM, CS_IO, DTACK, BERR
  );

  modport slave (
    input  AS, UDS, LDS, RW, ADDR_IN, DTACK_DRAM,
    output CS_DRAM, CS_ROM, CS_IO, DTACK, BERR
  );
endinterface

// File: rtl/bus_timer.sv
// Wait-state down-counter and non-wrapping bus-error timeout counter.
module bus_timer #(
  parameter int unsigned WAIT_W  = 3,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              run,
  output logic              wait_zero_c,
  output logic              timeout_c
);

  localparam int unsigned TO_W = $clog2(TIMEOUT) + 1;

  logic [WAIT_W-1:0] wait_q;
  logic [TO_W-1:0]   tcnt_q;

  // Timeout counter saturates at TIMEOUT rather than wrapping
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wait_q <= '0;
      tcnt_q <= '0;
    end else if (load) begin
      wait_q <= load_val;
      tcnt_q <= '0;
    end else if (run) begin
      if (wait_q != '0) wait_q <= wait_q - WAIT_W'(1);
      if (tcnt_q != TO_W'(TIMEOUT)) tcnt_q <= tcnt_q + TO_W'(1);
    end
  end

  assign wait_zero_c = (wait_q == '0);
  // Flags the ACTIVE edge on which the count reaches TIMEOUT
  assign timeout_c   = (tcnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_decoder.sv
// Address decoder and cycle terminator: chip selects, wait-state DTACK,
// DRAM acknowledge pass-through, boot ROM overlay and bus-error timeout.
module bus_decoder
  import bus_pkg::*;
#(
  parameter int unsigned ROM_WAIT     = ROM_WAIT_DEF,
  parameter int unsigned IO_WAIT      = IO_WAIT_DEF,
  parameter int unsigned BERR_TIMEOUT = BERR_TIMEOUT_DEF,
  parameter int unsigned BOOT_CYCLES  = BOOT_CYCLES_DEF
) (
  input logic          CLK,
  input logic          RST,
  bus_decoder_if.slave bus
);

  localparam int unsigned MAX_WAIT = (ROM_WAIT > IO_WAIT) ? ROM_WAIT : IO_WAIT;
  localparam int unsigned WAIT_W   = $clog2(MAX_WAIT + 1) + 1;
  localparam int unsigned BOOT_W   = $clog2(BOOT_CYCLES + 1) + 1;

  logic [ST_W-1:0]   state_q, state_d;
  region_e           region_q, region_d;
  logic              wr_q, wr_d;
  logic              cs_dram_q, cs_dram_d;
  logic              cs_rom_q, cs_rom_d;
  logic              cs_io_q, cs_io_d;
  logic              dtack_q, dtack_d;
  logic              berr_q, berr_d;
  logic [BOOT_W-1:0] boot_q, boot_d;

  logic              tmr_load;
  logic              tmr_run;
  logic [WAIT_W-1:0] tmr_val;
  logic              wait_zero_c;
  logic              timeout_c;
  logic              done_c;
  logic              overlay_c;
  region_e           dec_region_c;
  logic              unused_strobes;

  assign unused_strobes = bus.UDS & bus.LDS;
  assign overlay_c      = (boot_q < BOOT_W'(BOOT_CYCLES));
  assign dec_region_c   = decode(bus.ADDR_IN, overlay_c);

  bus_timer #(
    .WAIT_W  (WAIT_W),
    .TIMEOUT (BERR_TIMEOUT)
  ) u_timer (
    .CLK         (CLK),
    .RST         (RST),
    .load        (tmr_load),
    .load_val    (tmr_val),
    .run         (tmr_run),
    .wait_zero_c (wait_zero_c),
    .timeout_c   (timeout_c)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      region_q  <= REGION_NONE;
      wr_q      <= 1'b0;
      cs_dram_q <= 1'b1;
      cs_rom_q  <= 1'b1;
      cs_io_q   <= 1'b1;
      dtack_q   <= 1'b1;
      berr_q    <= 1'b1;
      boot_q    <= '0;
    end else begin
      state_q   <= state_d;
      region_q  <= region_d;
      wr_q      <= wr_d;
      cs_dram_q <= cs_dram_d;
      cs_rom_q  <= cs_rom_d;
      cs_io_q   <= cs_io_d;
      dtack_q   <= dtack_d;
      berr_q    <= berr_d;
      boot_q    <= boot_d;
    end
  end

  // Next state; AS released in ACTIVE or TERM ends the cycle ahead of any other event
  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    wr_d      = wr_q;
    cs_dram_d = cs_dram_q;
    cs_rom_d  = cs_rom_q;
    cs_io_d   = cs_io_q;
    dtack_d   = dtack_q;
    berr_d    = berr_q;
    boot_d    = boot_q;
    tmr_load  = 1'b0;
    tmr_run   = 1'b0;
    tmr_val   = WAIT_W'(ROM_WAIT);
    done_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!bus.AS) begin
          region_d  = dec_region_c;
          wr_d      = !bus.RW;
          cs_dram_d = (dec_region_c != REGION_DRAM);
          cs_rom_d  = (dec_region_c != REGION_ROM);
          cs_io_d   = (dec_region_c != REGION_IO);
          tmr_load  = 1'b1;
          tmr_val   = (dec_region_c == REGION_IO) ? WAIT_W'(IO_WAIT) : WAIT_W'(ROM_WAIT);
          state_d   = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        tmr_run = 1'b1;
        if (bus.AS) begin
          done_c = 1'b1;
        end else if (region_q == REGION_ROM && wr_q) begin
          berr_d  = 1'b0;
          state_d = ST_TERM;
        end else if (region_q == REGION_DRAM && !bus.DTACK_DRAM) begin
          dtack_d = 1'b0;
          state_d = ST_TERM;
        end else if ((region_q == REGION_ROM || region_q == REGION_IO) && wait_zero_c) begin
          dtack_d = 1'b0;
          state_d = ST_TERM;
        end else if (timeout_c) begin
          berr_d  = 1'b0;
          state_d = ST_TERM;
        end
      end
      ST_TERM: begin
        if (bus.AS) done_c = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (done_c) begin
      cs_dram_d = 1'b1;
      cs_rom_d  = 1'b1;
      cs_io_d   = 1'b1;
      dtack_d   = 1'b1;
      berr_d    = 1'b1;
      state_d   = ST_IDLE;
      if (boot_q != BOOT_W'(BOOT_CYCLES)) boot_d = boot_q + BOOT_W'(1);
    end
  end

  assign bus.CS_DRAM = cs_dram_q;
  assign bus.CS_ROM  = cs_rom_q;
  assign bus.CS_IO   = cs_io_q;
  assign bus.BERR    = berr_q;
  // DRAM acknowledge passes straight through, but never alongside a bus error
  assign bus.DTACK   = dtack_q & ~(~cs_dram_q & ~bus.DTACK_DRAM & berr_q);

endmodule

// File: tb/tb_bus_decoder.sv
// Directed bench for bus_decoder; outputs packed as {CS_DRAM,CS_ROM,CS_IO,DTACK,BERR}.
module tb_bus_decoder;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  bus_decoder_if bus ();

  bus_decoder #(
    .ROM_WAIT     (2),
    .IO_WAIT      (4),
    .BERR_TIMEOUT (64),
    .BOOT_CYCLES  (4)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [4:0] outs();
    return {bus.CS_DRAM, bus.CS_ROM, bus.CS_IO, bus.DTACK, bus.BERR};
  endfunction

  task automatic check(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = outs();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [23:0] a, input logic rw);
    @(negedge CLK);
    bus.ADDR_IN = a[23:1];
    bus.RW      = rw;
    bus.AS      = 1'b0;
    bus.UDS     = 1'b0;
    bus.LDS     = 1'b0;
  endtask

  task automatic release_bus(input string tag);
    bus.AS  = 1'b1;
    bus.UDS = 1'b1;
    bus.LDS = 1'b1;
    @(negedge CLK);
    check(tag, 5'b11111);
  endtask

  // Wait-state cycle: DTACK first seen low w+1 edges after AS is sampled
  task automatic wait_cycle(input string tag, input logic [23:0] a, input int w,
                            input logic [2:0] cs);
    start(a, 1'b1);
    @(negedge CLK);
    check({tag, "_cs"}, {cs, 2'b11});
    repeat (w) @(negedge CLK);
    check({tag, "_pre"}, {cs, 2'b11});
    @(negedge CLK);
    check({tag, "_dtack"}, {cs, 2'b01});
    release_bus({tag, "_rel"});
  endtask

  initial begin
    bus.AS         = 1'b1;
    bus.UDS        = 1'b1;
    bus.LDS        = 1'b1;
    bus.RW         = 1'b1;
    bus.ADDR_IN    = '0;
    bus.DTACK_DRAM = 1'b1;

    @(negedge CLK);
    check("reset", 5'b11111);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("post_reset", 5'b11111);

    // Boot overlay: low addresses hit ROM for the first four cycles
    wait_cycle("boot0", 24'h000000, 2, 3'b101);
    wait_cycle("boot1", 24'h000002, 2, 3'b101);
    wait_cycle("boot2", 24'h000004, 2, 3'b101);
    wait_cycle("boot3", 24'h000006, 2, 3'b101);

    // Fifth access at 0 reaches DRAM
    start(24'h000000, 1'b1);
    @(negedge CLK);
    check("dram0_cs", 5'b01111);
    bus.DTACK_DRAM = 1'b0;
    #1 check("dram0_pass", 5'b01101);
    @(negedge CLK);
    check("dram0_hold", 5'b01101);
    release_bus("dram0_rel");
    bus.DTACK_DRAM = 1'b1;

    // DRAM acknowledge five cycles after AS sampled
    start(24'h001234, 1'b1);
    repeat (5) @(negedge CLK);
    check("dram1_wait", 5'b01111);
    bus.DTACK_DRAM = 1'b0;
    #1 check("dram1_pass", 5'b01101);
    @(negedge CLK);
    check("dram1_hold", 5'b01101);
    release_bus("dram1_rel");
    bus.DTACK_DRAM = 1'b1;

    wait_cycle("io", 24'hE00010, 4, 3'b110);

    // Unmapped read ends by timeout
    start(24'h800000, 1'b1);
    @(negedge CLK);
    check("unmap_cs", 5'b11111);
    repeat (63) @(negedge CLK);
    check("unmap_pre", 5'b11111);
    @(negedge CLK);
    check("unmap_berr", 5'b11110);
    release_bus("unmap_rel");

    // ROM write faults on the first ACTIVE edge
    start(24'hF00000, 1'b0);
    @(negedge CLK);
    check("romwr_cs", 5'b10111);
    @(negedge CLK);
    check("romwr_berr", 5'b10110);
    release_bus("romwr_rel");

    // AS release on the timeout edge suppresses BERR
    start(24'h800000, 1'b1);
    repeat (64) @(negedge CLK);
    release_bus("race_rel");
    @(negedge CLK);
    check("race_idle", 5'b11111);

    // Late DRAM acknowledge after a timeout must not drive DTACK with BERR
    start(24'h000100, 1'b1);
    @(negedge CLK);
    check("dto_cs", 5'b01111);
    repeat (63) @(negedge CLK);
    check("dto_pre", 5'b01111);
    @(negedge CLK);
    check("dto_berr", 5'b01110);
    bus.DTACK_DRAM = 1'b0;
    #1 check("dto_excl", 5'b01110);
    release_bus("dto_rel");
    bus.DTACK_DRAM = 1'b1;

    // Asynchronous reset in the middle of an acknowledged DRAM cycle
    start(24'h000040, 1'b1);
    @(negedge CLK);
    bus.DTACK_DRAM = 1'b0;
    #1 check("mid_pass", 5'b01101);
    #2 RST = 1'b0;
    #1 check("mid_reset", 5'b11111);
    bus.DTACK_DRAM = 1'b1;
    bus.AS         = 1'b1;
    bus.UDS        = 1'b1;
    bus.LDS        = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("mid_idle", 5'b11111);

    // Overlay restored; aborted cycles also advance the boot count
    wait_cycle("reboot", 24'h000000, 2, 3'b101);
    for (int i = 0; i < 3; i++) begin
      start(24'h000000, 1'b1);
      @(negedge CLK);
      check("abort_cs", 5'b10111);
      release_bus("abort_rel");
    end
    start(24'h000000, 1'b1);
    @(negedge CLK);
    check("postboot_cs", 5'b01111);
    release_bus("postboot_rel");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_decoder.md
BUS_DECODER -- requirements
Module: bus_decoder

Interface
REQ-001 SHALL have port CLK, input, 1, system clock shared with CPU and dram_controller; all state changes on rising edge.
REQ-002 SHALL have port RST, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port AS, input, 1, CPU address strobe, active-low.
REQ-004 SHALL have ports UDS and LDS, input, 1 each, CPU data strobes, active-low.
REQ-005 SHALL have port RW, input, 1, high = read.
REQ-006 SHALL have port ADDR_IN, input, [23:1], CPU address.
REQ-007 SHALL have port DTACK_DRAM, input, 1, acknowledge from dram_controller, active-low.
REQ-008 SHALL have ports CS_DRAM, CS_ROM and CS_IO, output, 1 each, registered chip selects, active-low.
REQ-009 SHALL have port DTACK, output, 1, acknowledge to CPU, active-low.
REQ-010 SHALL have port BERR, output, 1, bus error to CPU, active-low, registered.
REQ-011 SHALL have parameters: ROM_WAIT, default 2, ROM wait cycles; IO_WAIT, default 4, IO wait cycles; BERR_TIMEOUT, default 64, cycles before bus error; BOOT_CYCLES, default 4, overlay bus cycles.

Function
REQ-012 Address map SHALL be: DRAM 0x000000-0x3FFFFF; IO 0xE00000-0xEFFFFF; ROM 0xF00000-0xFFFFFF; everything else unmapped.
REQ-013 While boot count < BOOT_CYCLES (overlay), addresses 0x000000-0x3FFFFF SHALL decode to ROM instead of DRAM.
REQ-014 Boot count SHALL increment on each return to IDLE from a terminated cycle, saturate at BOOT_CYCLES, and clear only on reset.
REQ-015 FSM SHALL have states IDLE, ACTIVE, TERM.
REQ-016 IDLE: on edge sampling AS low, register decode, assert exactly one CS (or none if unmapped), load wait counter, clear timeout counter, go ACTIVE; CS is low from the following cycle.
REQ-017 ACTIVE/ROM or IO: wait counter SHALL decrement each cycle; at zero, assert DTACK (registered) and go TERM; DTACK therefore goes low ROM_WAIT+1 or IO_WAIT+1 cycles after AS sampled low.
REQ-018 ACTIVE/DRAM: DTACK SHALL equal DTACK_DRAM combinationally while CS_DRAM is low; FSM SHALL go TERM on edge sampling DTACK_DRAM low.
REQ-019 ROM write (RW low, ROM decoded) SHALL assert BERR on the first ACTIVE edge, never DTACK, and go TERM.
REQ-020 Timeout counter SHALL increment every ACTIVE cycle; on reaching BERR_TIMEOUT without DTACK, BERR SHALL assert and FSM go TERM; unmapped accesses terminate only this way.
REQ-021 TERM: hold CS, DTACK, BERR until AS sampled high, then deassert all (high) and go IDLE.
REQ-022 AS sampled high in ACTIVE (aborted cycle) SHALL deassert all outputs and go IDLE, counting as a terminated cycle.
REQ-023 AS high and timeout expiry on the same edge: AS SHALL win; BERR not asserted.
REQ-024 DTACK and BERR SHALL never be low simultaneously.
REQ-025 Back-to-back cycles: a new AS low SHALL be accepted no earlier than the edge after returning to IDLE.
REQ-026 Timeout counter width SHALL be clog2(BERR_TIMEOUT)+1 bits and SHALL not wrap.

Reset
REQ-027 Reset SHALL force: CS_DRAM, CS_ROM, CS_IO, DTACK, BERR high; state IDLE; boot count 0 (overlay on); wait and timeout counters 0.
REQ-028 Reset asserted mid-cycle SHALL take effect immediately; release SHALL resume in IDLE with no spurious CS.

Structure
REQ-029 Address-map bases/limits, default wait counts, BERR_TIMEOUT and FSM state encoding SHALL live in shared package bus_pkg.
REQ-030 Wait/timeout counting SHALL be one sub-module, bus_timer (load, decrement-to-zero flag, timeout flag).

Verification
REQ-031 After reset, 4 reads at 0x000000/0x000002/0x000004/0x000006 -> CS_ROM low each, DTACK low 3 cycles after AS; 5th read at 0x000000 -> CS_DRAM low, CS_ROM high.
REQ-032 DRAM read 0x001234, DTACK_DRAM driven low 5 cycles later -> DTACK follows same cycle; AS high -> all outputs high next edge.
REQ-033 IO read 0xE00010 -> CS_IO low, DTACK low exactly 5 cycles after AS sampled low.
REQ-034 Read 0x800000 (unmapped) -> no CS, BERR low after 64 ACTIVE cycles, DTACK stays high.
REQ-035 Write 0xF00000 after boot -> BERR low one cycle later; AS high at timeout edge on unmapped read -> no BERR.
REQ-036 Reset pulse while CS_DRAM low and DTACK low -> all outputs high immediately, boot count 0.
